// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage: permutes the shared 256x8 S memory with a 3-byte key.
// Ports: clk, rst (sync, active-high); en/rdy start handshake; key[23:0] (byte 0 = key[23:16]);
//        s_addr/s_wrdata/s_wren drive the single-port S RAM, s_rddata returns the read one cycle later.
// Build option: define RC4_KSA_INIT_EN to fill S with the identity permutation before scheduling.
module rc4_ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  s_addr,
  input  logic [7:0]  s_rddata,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD_I  = 3'd1;
  localparam logic [2:0] ST_CAP_I = 3'd2;
  localparam logic [2:0] ST_RD_J  = 3'd3;
  localparam logic [2:0] ST_CAP_J = 3'd4;
  localparam logic [2:0] ST_WR_J  = 3'd5;
  localparam logic [2:0] ST_WR_I  = 3'd6;
`ifdef RC4_KSA_INIT_EN
  localparam logic [2:0] ST_INIT  = 3'd7;
`endif

  localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [1:0]  kidx_q, kidx_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic        wren_q, wren_d;

  logic [7:0]  kbyte;
  logic [7:0]  j_next;

  always_comb begin
    case (kidx_q)
      2'd0:    kbyte = key_q[23:16];
      2'd1:    kbyte = key_q[15:8];
      default: kbyte = key_q[7:0];
    endcase
  end

  assign j_next = j_q + s_rddata + kbyte;

  // Output registers are loaded with the values of the state being entered,
  // so every RAM control signal comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    kidx_d   = kidx_q;
    key_d    = key_q;
    si_d     = si_q;
    sj_d     = sj_q;
    rdy_d    = 1'b0;
    addr_d   = 8'd0;
    wrdata_d = 8'd0;
    wren_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (en) begin
          key_d  = key;
          i_d    = 8'd0;
          j_d    = 8'd0;
          kidx_d = 2'd0;
          rdy_d  = 1'b0;
`ifdef RC4_KSA_INIT_EN
          state_d = ST_INIT;
          wren_d  = 1'b1;
`else
          state_d = ST_RD_I;
`endif
        end
      end
`ifdef RC4_KSA_INIT_EN
      ST_INIT: begin
        if (i_q == 8'hFF) begin
          i_d     = 8'd0;
          state_d = ST_RD_I;
        end else begin
          i_d      = i_q + 8'd1;
          addr_d   = i_q + 8'd1;
          wrdata_d = i_q + 8'd1;
          wren_d   = 1'b1;
        end
      end
`endif
      ST_RD_I: begin
        state_d = ST_CAP_I;
      end
      ST_CAP_I: begin
        si_d    = s_rddata;
        j_d     = j_next;
        addr_d  = j_next;
        state_d = ST_RD_J;
      end
      ST_RD_J: begin
        state_d = ST_CAP_J;
      end
      ST_CAP_J: begin
        sj_d     = s_rddata;
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
        state_d  = ST_WR_J;
      end
      ST_WR_J: begin
        addr_d   = i_q;
        wrdata_d = sj_q;
        wren_d   = 1'b1;
        state_d  = ST_WR_I;
      end
      ST_WR_I: begin
        if (i_q == 8'hFF) begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
          addr_d  = i_q + 8'd1;
          state_d = ST_RD_I;
        end
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      i_q      <= 8'd0;
      j_q      <= 8'd0;
      kidx_q   <= 2'd0;
      key_q    <= 24'd0;
      si_q     <= 8'd0;
      sj_q     <= 8'd0;
      rdy_q    <= 1'b1;
      addr_q   <= 8'd0;
      wrdata_q <= 8'd0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kidx_q   <= kidx_d;
      key_q    <= key_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      rdy_q    <= rdy_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign rdy      = rdy_q;
  assign s_addr   = addr_q;
  assign s_wrdata = wrdata_q;
  assign s_wren   = wren_q;

endmodule

// File: tb/tb_rc4_ksa.sv
// Directed bench for rc4_ksa: behavioural S RAM, write log and a software KSA model.
// Honours RC4_KSA_INIT_EN for run length and the starting contents of S.
module tb_rc4_ksa;

`ifdef RC4_KSA_INIT_EN
  localparam int RUN_LEN = 1792;
  localparam int PRE     = 256;
`else
  localparam int RUN_LEN = 1536;
  localparam int PRE     = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] key = 24'd0;
  logic        rdy;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  logic [7:0]  mem [256];
  logic [7:0]  exp_s [256];
  logic [7:0]  rd_q;
  logic        ld_id = 1'b0;
  logic [7:0]  log_a [4096];
  logic [7:0]  log_d [4096];
  int          wr_cnt = 0;
  int          base;
  int          checks = 0;
  int          errors = 0;
  int          n;
  int          hi;

  always #5 clk = ~clk;

  rc4_ksa dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  assign s_rddata = rd_q;

  always @(posedge clk) begin
    if (ld_id) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (s_wren) begin
      mem[s_addr] <= s_wrdata;
      log_a[wr_cnt % 4096] <= s_addr;
      log_d[wr_cnt % 4096] <= s_wrdata;
      wr_cnt <= wr_cnt + 1;
    end
    rd_q <= mem[s_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity();
    @(negedge clk);
    ld_id = 1'b1;
    @(negedge clk);
    ld_id = 1'b0;
  endtask

  task automatic exp_identity();
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
  endtask

  task automatic ksa_model(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb [3];
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      j = j + exp_s[i] + kb[i % 3];
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic cmp_s(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a++)
      if (mem[a] !== exp_s[a]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run(input logic [23:0] k, input bit disturb, output int cnt);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    cnt = 0;
    while (rdy !== 1'b1 && cnt < 4000) begin
      if (disturb) begin
        if (cnt == 100) key = ~k;
        en = (cnt % 50 == 7) && (cnt < 1500);
      end
      @(posedge clk);
      #1;
      cnt++;
    end
    en  = 1'b0;
    key = k;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", s_wren, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wrdata", s_wrdata, 0);
    rst = 1'b0;
    base = wr_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_writes", wr_cnt - base, 0);
    chk("idle_rdy", rdy, 1);

    // swap sequence
    load_identity();
    base = wr_cnt + PRE;
    run(24'h010203, 1'b0, n);
    chk("swap_len", n, RUN_LEN);
    chk("swap_w0_addr", log_a[(base + 0) % 4096], 8'd1);
    chk("swap_w0_data", log_d[(base + 0) % 4096], 8'd0);
    chk("swap_w1_addr", log_a[(base + 1) % 4096], 8'd0);
    chk("swap_w1_data", log_d[(base + 1) % 4096], 8'd1);
    chk("swap_w2_addr", log_a[(base + 2) % 4096], 8'd3);
    chk("swap_w2_data", log_d[(base + 2) % 4096], 8'd0);
    chk("swap_w3_addr", log_a[(base + 3) % 4096], 8'd1);
    chk("swap_w3_data", log_d[(base + 3) % 4096], 8'd3);
    chk("swap_total_writes", wr_cnt - base, 512);
    exp_identity();
    ksa_model(24'h010203);
    cmp_s("swap_final_s");

    // self-swap
    load_identity();
    base = wr_cnt + PRE;
    run(24'h000000, 1'b0, n);
    chk("self_len", n, RUN_LEN);
    chk("self_w0_addr", log_a[(base + 0) % 4096], 8'd0);
    chk("self_w0_data", log_d[(base + 0) % 4096], 8'd0);
    chk("self_w1_addr", log_a[(base + 1) % 4096], 8'd0);
    chk("self_w1_data", log_d[(base + 1) % 4096], 8'd0);
    exp_identity();
    ksa_model(24'h000000);
    cmp_s("self_final_s");

    // full run, key change and en pulses mid-run
    load_identity();
    run(24'h1E4600, 1'b1, n);
    chk("full_len", n, RUN_LEN);
    exp_identity();
    ksa_model(24'h1E4600);
    cmp_s("full_final_s");
    chk("full_s0", mem[0], exp_s[0]);

    // en held high: back-to-back runs
    load_identity();
    @(negedge clk);
    key = 24'h5A17C3;
    en  = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (rdy !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_len1", n, RUN_LEN);
    hi = 0;
    while (rdy === 1'b1 && hi < 10) begin
      @(posedge clk);
      #1;
      hi++;
    end
    en = 1'b0;
    chk("b2b_rdy_high_cycles", hi, 1);
    n = 0;
    while (rdy !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_len2", n, RUN_LEN);
    exp_identity();
    ksa_model(24'h5A17C3);
`ifndef RC4_KSA_INIT_EN
    ksa_model(24'h5A17C3);
`endif
    cmp_s("b2b_final_s");

    // reset mid-run
    load_identity();
    @(negedge clk);
    key = 24'h3C9D21;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk("mid_busy", rdy, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_rdy", rdy, 1);
    chk("mid_rst_wren", s_wren, 0);
    chk("mid_rst_addr", s_addr, 0);
    chk("mid_rst_wrdata", s_wrdata, 0);
    rst = 1'b0;
`ifdef RC4_KSA_INIT_EN
    exp_identity();
`else
    for (int a = 0; a < 256; a++) exp_s[a] = mem[a];
`endif
    ksa_model(24'hA5C3F0);
    run(24'hA5C3F0, 1'b0, n);
    chk("mid_rerun_len", n, RUN_LEN);
    cmp_s("mid_rerun_final_s");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
